// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with valid/ready handshake,
// one-word holding buffer, optional parity and 1/2 stop bits.
module uart_tx_param #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DATA_W-1:0]  P_DATA,
  input  logic               DATA_VALID,
  output logic               DATA_READY,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic               STOP2,
  input  logic [PRESC_W-1:0] PRESCALE,
  output logic               TX_OUT,
  output logic               BUSY
);
  localparam int BW = $clog2(DATA_W);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  // A word travels with its framing config; parity is resolved at capture.
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               par_en;
    logic               par;
    logic               stop2;
    logic [PRESC_W-1:0] pm1;
  } word_t;
  state_t state_q, state_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0] idx_q, idx_d;
  word_t in_w, cur_q, cur_d, buf_q, buf_d;
  logic full_q, full_d, rdy_q, rdy_d, tx_q, tx_d, busy_q, busy_d;
  logic acc, tick, last, start_new, drain, to_buf;
  assign in_w = {P_DATA, PAR_EN, ^P_DATA ^ PAR_TYP, STOP2,
                 (PRESCALE == '0) ? '0 : PRESCALE - 1'b1};
  assign acc       = DATA_VALID && rdy_q;
  assign tick      = cnt_q == '0;
  assign last      = state_q == STOP && tick && idx_q == BW'(cur_q.stop2);
  assign start_new = (state_q == IDLE || last) && (full_q || acc);
  assign drain     = start_new && full_q;
  assign to_buf    = acc && (full_q || !start_new);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    buf_d   = to_buf ? in_w : buf_q;
    full_d  = to_buf || (full_q && !drain);
    if (start_new) begin
      cur_d   = full_q ? buf_q : in_w;
      state_d = START;
      cnt_d   = cur_d.pm1;
      idx_d   = '0;
    end else if (state_q != IDLE) begin
      if (!tick) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        cnt_d = cur_q.pm1;
        unique case (state_q)
          START: begin
            state_d = DATA;
            idx_d   = '0;
          end
          DATA: begin
            cur_d.data = cur_q.data >> 1;
            idx_d      = idx_q + 1'b1;
            if (idx_q == BW'(DATA_W - 1)) begin
              state_d = cur_q.par_en ? PARITY : STOP;
              idx_d   = '0;
            end
          end
          PARITY: begin
            state_d = STOP;
            idx_d   = '0;
          end
          STOP: begin
            state_d = last ? IDLE : STOP;
            idx_d   = last ? '0 : idx_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
    tx_d   = state_d == START ? 1'b0 : state_d == DATA ? cur_d.data[0] :
             state_d == PARITY ? cur_d.par : 1'b1;
    busy_d = state_d != IDLE;
    // Ready returns one cycle after a drain so a refill never races the drain.
    rdy_d  = !full_d && !drain;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      cur_q   <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      rdy_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      rdy_q   <= rdy_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end
  assign DATA_READY = rdy_q;
  assign TX_OUT     = tx_q;
  assign BUSY       = busy_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench; stimulus queues hand-written frame
// patterns, a monitor per instance checks the line cycle by cycle.
module tb_uart_tx_param;
  typedef struct {
    logic [63:0] bits;
    int nbits;
    int p;
    bit nb;
  } exp_t;
  logic CLK = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic [7:0] pd_a = '0;
  logic [6:0] pd_b = '0;
  logic vld_a = 1'b0, vld_b = 1'b0;
  logic par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0;
  logic [7:0] presc = 8'd1;
  logic [1:0] tx_w, busy_w, rdy_w;
  logic [1:0] mon_en = 2'b11;
  int checks = 0, failures = 0;
  exp_t q0[$], q1[$];
  uart_tx_param #(.DATA_W(8), .PRESC_W(8)) dut_a (
    .CLK(CLK), .RST(rst_a), .P_DATA(pd_a), .DATA_VALID(vld_a),
    .DATA_READY(rdy_w[0]), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STOP2(stop2), .PRESCALE(presc), .TX_OUT(tx_w[0]), .BUSY(busy_w[0])
  );
  uart_tx_param #(.DATA_W(7), .PRESC_W(8)) dut_b (
    .CLK(CLK), .RST(rst_b), .P_DATA(pd_b), .DATA_VALID(vld_b),
    .DATA_READY(rdy_w[1]), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .STOP2(stop2), .PRESCALE(presc), .TX_OUT(tx_w[1]), .BUSY(busy_w[1])
  );
  always #5 CLK = ~CLK;
  function automatic int qsize(input int id);
    return id == 0 ? q0.size() : q1.size();
  endfunction
  function automatic exp_t qpop(input int id);
    return id == 0 ? q0.pop_front() : q1.pop_front();
  endfunction
  // Pattern string is written in line order: first character is the start bit.
  function automatic void push_exp(input int id, input string s, input int p, input bit nb);
    exp_t e;
    e.bits = '0;
    for (int i = 0; i < s.len(); i++) e.bits[i] = (s[i] == 8'h31);
    e.nbits = s.len();
    e.p = p;
    e.nb = nb;
    if (id == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic mon(input int id);
    exp_t e;
    int bad;
    logic bt, bb;
    forever begin
      @(negedge CLK);
      while (mon_en[id] && busy_w[id] === 1'b1) begin
        if (qsize(id) == 0) begin
          checks++;
          failures++;
          $display("FAIL mon%0d: unexpected frame", id);
          for (int n = 0; n < 1000 && busy_w[id] === 1'b1; n++) @(negedge CLK);
          break;
        end
        e = qpop(id);
        bad = -1;
        bt = 1'b0;
        bb = 1'b0;
        for (int k = 0; k < e.nbits * e.p; k++) begin
          if (k > 0) @(negedge CLK);
          if (bad < 0 && (tx_w[id] !== e.bits[k / e.p] || busy_w[id] !== 1'b1)) begin
            bad = k;
            bt = tx_w[id];
            bb = busy_w[id];
          end
        end
        checks++;
        if (bad >= 0) begin
          failures++;
          $display("FAIL mon%0d frame: cycle %0d tx=%b busy=%b expected tx=%b busy=1",
                   id, bad, bt, bb, e.bits[bad / e.p]);
        end
        @(negedge CLK);
        chk($sformatf("mon%0d after-frame {busy,tx}", id), {30'd0, busy_w[id], tx_w[id]},
            e.nb ? 32'd2 : 32'd1);
      end
    end
  endtask
  initial mon(0);
  initial mon(1);
  task automatic send(input int id, input logic [7:0] d);
    @(negedge CLK);
    if (id == 0) begin
      pd_a = d;
      vld_a = 1'b1;
    end else begin
      pd_b = d[6:0];
      vld_b = 1'b1;
    end
    for (int n = 0; n < 500 && rdy_w[id] !== 1'b1; n++) @(negedge CLK);
    chk($sformatf("send%0d ready", id), {31'd0, rdy_w[id]}, 32'd1);
    @(posedge CLK);
    #1;
    vld_a = 1'b0;
    vld_b = 1'b0;
  endtask
  task automatic drain(input int id);
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      if (qsize(id) == 0 && busy_w[id] === 1'b0) return;
    end
    chk($sformatf("drain%0d timeout", id), 32'd1, 32'd0);
  endtask
  task automatic cfg(input logic pe, input logic pt, input logic s2, input logic [7:0] p);
    par_en = pe;
    par_typ = pt;
    stop2 = s2;
    presc = p;
  endtask
  initial begin
    #1 rst_a = 1'b0;
    rst_b = 1'b0;
    #2 chk("reset {tx,busy,ready}", {29'd0, tx_w[0], busy_w[0], rdy_w[0]}, 32'b100);
    @(negedge CLK);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge CLK);
    chk("ready after release", {31'd0, rdy_w[0]}, 32'd1);
    cfg(1, 0, 0, 1);
    push_exp(0, "01010010101", 1, 0);
    send(0, 8'hA5);
    drain(0);
    cfg(1, 1, 0, 1);
    push_exp(0, "01000000001", 1, 0);
    send(0, 8'h01);
    drain(0);
    push_exp(0, "01100000011", 1, 0);
    send(0, 8'h03);
    drain(0);
    cfg(0, 1, 0, 1);
    push_exp(0, "0110000001", 1, 0);
    send(0, 8'h03);
    drain(0);
    cfg(0, 0, 1, 4);
    push_exp(0, "00000000011", 4, 0);
    send(0, 8'h00);
    drain(0);
    cfg(1, 0, 0, 0);
    push_exp(0, "01010010101", 1, 0);
    send(0, 8'hA5);
    drain(0);
    cfg(0, 0, 0, 1);
    push_exp(0, "0101010101", 1, 1);
    push_exp(0, "0111100001", 1, 0);
    send(0, 8'h55);
    send(0, 8'h0F);
    chk("b2b ready low after buffer accept", {31'd0, rdy_w[0]}, 32'd0);
    repeat (10) @(negedge CLK);
    chk("b2b ready low at second start", {31'd0, rdy_w[0]}, 32'd0);
    @(negedge CLK);
    chk("b2b ready high after second start", {31'd0, rdy_w[0]}, 32'd1);
    drain(0);
    cfg(1, 0, 0, 1);
    push_exp(0, "00000000111", 1, 0);
    send(0, 8'h80);
    par_en = 1'b0;
    stop2 = 1'b1;
    drain(0);
    cfg(1, 0, 0, 2);
    push_exp(1, "0111111111", 2, 0);
    send(1, 8'h7F);
    drain(1);
    mon_en[1] = 1'b0;
    cfg(0, 0, 0, 2);
    send(1, 8'h00);
    repeat (5) @(negedge CLK);
    #2 rst_b = 1'b0;
    #1 chk("mid-frame reset {tx,busy,ready}", {29'd0, tx_w[1], busy_w[1], rdy_w[1]}, 32'b100);
    @(negedge CLK);
    rst_b = 1'b1;
    begin
      logic ok;
      ok = 1'b1;
      for (int n = 0; n < 30; n++) begin
        @(negedge CLK);
        if (busy_w[1] !== 1'b0 || tx_w[1] !== 1'b1) ok = 1'b0;
      end
      chk("no frame resumes after reset", {31'd0, ok}, 32'd1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL global timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
endmodule
